// File: rtl/display_pkg.sv
// Shared definitions for the seven-segment display path: source select codes,
// active-low segment constants ({g,f,e,d,c,b,a}) and the BCD glyph table.
package display_pkg;

  typedef enum logic [1:0] {
    SEL_ENTRY  = 2'b00,
    SEL_S1     = 2'b01,
    SEL_S2     = 2'b10,
    SEL_RESULT = 2'b11
  } display_sel_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Entry n is the glyph for BCD digit n.
  localparam logic [9:0][6:0] SEG_GLYPHS = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low seven-segment decoder; A-F show a dash.
module bcd_to_seg7
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (bcd <= 4'd9) begin
      seg = SEG_GLYPHS[bcd];
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode seven-segment scan driver with per-frame source
// latching, leading-zero blanking and anti-ghosting blank time per digit.
module seg7_scan_driver
  import display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 10,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned BLANK_CYC  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*NUM_DIGITS-1:0]   in_val,
  input  logic [4*NUM_DIGITS-1:0]   S1,
  input  logic [4*NUM_DIGITS-1:0]   S2,
  input  logic [4*NUM_DIGITS-1:0]   result,
  input  logic [1:0]                display_sel,
  input  logic                      disp_en,
  output logic [NUM_DIGITS-1:0]     an,
  output logic [6:0]                seg
);

  localparam int unsigned VW = 4 * NUM_DIGITS;
  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0]         PCNT_LAST = PW'(SCAN_DIV - 1);
  localparam logic [DW-1:0]         DIDX_LAST = DW'(NUM_DIGITS - 1);
  localparam logic [PW:0]           BLANK_LIM = (PW + 1)'(BLANK_CYC);
  localparam logic [NUM_DIGITS-1:0] MASK_RST  = ~(NUM_DIGITS'(1));

  logic [PW-1:0]         pcnt_q, pcnt_d;
  logic [DW-1:0]         didx_q, didx_d;
  logic [VW-1:0]         frame_q, frame_d;
  logic [NUM_DIGITS-1:0] mask_q, mask_d;
  logic                  reload_q, reload_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;

  logic [VW-1:0]         src_val;
  logic [NUM_DIGITS-1:0] src_mask;
  logic                  nz_seen;
  logic                  pcnt_wrap;
  logic                  frame_load;
  logic [3:0]            cur_nib;
  logic [6:0]            dec_seg;

  always_comb begin
    src_val = in_val;
    case (display_sel_e'(display_sel))
      SEL_ENTRY:  src_val = in_val;
      SEL_S1:     src_val = S1;
      SEL_S2:     src_val = S2;
      SEL_RESULT: src_val = result;
      default:    src_val = in_val;
    endcase
  end

  // Walk from the top digit down; a digit is blanked until a nonzero
  // (or invalid) nibble has been seen at or above it.
  always_comb begin
    nz_seen  = 1'b0;
    src_mask = '0;
    for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
      nz_seen     = nz_seen | (src_val[4*i +: 4] != 4'd0);
      src_mask[i] = ~nz_seen;
    end
    src_mask[0] = 1'b0;
  end

  always_comb begin
    pcnt_wrap  = (pcnt_q == PCNT_LAST);
    frame_load = reload_q | (pcnt_wrap & (didx_q == DIDX_LAST));

    pcnt_d   = pcnt_wrap ? '0 : pcnt_q + 1'b1;
    didx_d   = didx_q;
    frame_d  = frame_q;
    mask_d   = mask_q;
    reload_d = reload_q;

    if (pcnt_wrap) begin
      didx_d = (didx_q == DIDX_LAST) ? '0 : didx_q + 1'b1;
    end

    if (frame_load) begin
      frame_d  = src_val;
      mask_d   = src_mask;
      reload_d = 1'b0;
    end
  end

  assign cur_nib = frame_q[4*didx_q +: 4];

  bcd_to_seg7 u_dec (
    .bcd (cur_nib),
    .seg (dec_seg)
  );

  always_comb begin
    an_d  = '1;
    seg_d = dec_seg;
    if (({1'b0, pcnt_q} >= BLANK_LIM) && disp_en && !mask_q[didx_q]) begin
      an_d[didx_q] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q   <= '0;
      didx_q   <= '0;
      frame_q  <= '0;
      mask_q   <= MASK_RST;
      reload_q <= 1'b1;
      an_q     <= '1;
      seg_q    <= SEG_BLANK;
    end else begin
      pcnt_q   <= pcnt_d;
      didx_q   <= didx_d;
      frame_q  <= frame_d;
      mask_q   <= mask_d;
      reload_q <= reload_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule
